// File: rtl/dir_read_resp_router.sv
// Purpose: steers directory SRAM read data back to the core pipeline or a coherence response FIFO.
// Latency: core responses exactly RdLatency cycles after grant; coherence responses RdLatency+1 or later.
// Backpressure: core path never stalls; coherence path stalls the arbiter through coh_stall_o credits.
module dir_read_resp_router #(
  parameter int unsigned NumWays     = 4,
  parameter int unsigned RdLatency   = 1,
  parameter int unsigned CohBufDepth = 2,
  parameter type hpdcache_way_vector_t = logic [NumWays-1:0],
  parameter type hpdcache_dir_entry_t  = logic [15:0]
) (
  input  logic                                 clk_i,
  input  logic                                 rst_ni,
  input  logic                                 gnt_valid_i,
  input  logic                                 gnt_idx_i,
  input  hpdcache_way_vector_t                 gnt_cs_i,
  input  hpdcache_way_vector_t                 gnt_we_i,
  input  hpdcache_dir_entry_t  [NumWays-1:0]   dir_rentry_i,
  output logic                                 core_rvalid_o,
  output hpdcache_way_vector_t                 core_rways_o,
  output hpdcache_dir_entry_t  [NumWays-1:0]   core_rentry_o,
  output logic                                 coh_rvalid_o,
  input  logic                                 coh_rready_i,
  output hpdcache_way_vector_t                 coh_rways_o,
  output hpdcache_dir_entry_t  [NumWays-1:0]   coh_rentry_o,
  output logic                                 coh_stall_o,
  output logic                                 overflow_o
);

  localparam int unsigned CntW = $clog2(CohBufDepth + RdLatency + 1);
  localparam int unsigned PtrW = (CohBufDepth > 1) ? $clog2(CohBufDepth) : 1;

  typedef hpdcache_dir_entry_t [NumWays-1:0] entries_t;

  // Tracking pipeline: one stage per SRAM latency cycle, last stage aligns with read data.
  logic [RdLatency-1:0]  pipe_vld;
  logic [RdLatency-1:0]  pipe_idx;
  hpdcache_way_vector_t  pipe_ways [RdLatency];

  // Coherence response FIFO storage and bookkeeping.
  hpdcache_way_vector_t  mem_ways [CohBufDepth];
  entries_t              mem_ent  [CohBufDepth];
  logic [PtrW-1:0]       wr_ptr;
  logic [PtrW-1:0]       rd_ptr;
  logic [CntW-1:0]       fifo_cnt;
  logic                  overflow_q;

  hpdcache_way_vector_t  rd_ways;
  logic                  is_rd;
  logic                  coh_drop;
  logic                  track;
  logic [CntW-1:0]       inflight;
  logic [CntW-1:0]       used;
  logic                  stall_raw;
  logic                  al_vld;
  logic                  al_idx;
  hpdcache_way_vector_t  al_ways;
  entries_t              masked;
  logic                  push;
  logic                  pop;
  logic                  full;
  logic                  push_ok;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(CohBufDepth - 1)) ? '0 : p + PtrW'(1);
  endfunction

  // Classify the current grant: a read needs at least one selected, non-written way.
  always_comb begin
    rd_ways  = gnt_cs_i & ~gnt_we_i;
    is_rd    = gnt_valid_i && (rd_ways != '0);
    coh_drop = is_rd && gnt_idx_i && stall_raw;
    track    = is_rd && !coh_drop;
  end

  // Credit accounting depends only on registered state, never on the grant inputs.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < RdLatency; i++) begin
      inflight = inflight + CntW'(pipe_vld[i] & pipe_idx[i]);
    end
    used      = fifo_cnt + inflight;
    stall_raw = (used >= CntW'(CohBufDepth));
  end

  // Valid bits of the tracking pipeline; the SRAM never stalls so it shifts every cycle.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      pipe_vld <= '0;
    end else begin
      pipe_vld[0] <= track;
      for (int i = 1; i < RdLatency; i++) begin
        pipe_vld[i] <= pipe_vld[i-1];
      end
    end
  end

  // Payload of the tracking pipeline; qualified by pipe_vld so it needs no reset.
  always_ff @(posedge clk_i) begin
    pipe_idx[0]  <= gnt_idx_i;
    pipe_ways[0] <= rd_ways;
    for (int i = 1; i < RdLatency; i++) begin
      pipe_idx[i]  <= pipe_idx[i-1];
      pipe_ways[i] <= pipe_ways[i-1];
    end
  end

  // Aligned stage meets SRAM data; ways that were not read are zeroed.
  always_comb begin
    al_vld  = pipe_vld[RdLatency-1];
    al_idx  = pipe_idx[RdLatency-1];
    al_ways = pipe_ways[RdLatency-1];
    masked  = '0;
    for (int w = 0; w < NumWays; w++) begin
      masked[w] = al_ways[w] ? dir_rentry_i[w] : '0;
    end
  end

  // Core responses are delivered in the data-return cycle without buffering.
  always_comb begin
    core_rvalid_o = rst_ni && al_vld && !al_idx;
    core_rways_o  = core_rvalid_o ? al_ways : '0;
    core_rentry_o = core_rvalid_o ? masked : '0;
  end

  // FIFO handshake; a push into a full FIFO is only accepted alongside a pop.
  always_comb begin
    full         = (fifo_cnt == CntW'(CohBufDepth));
    coh_rvalid_o = rst_ni && (fifo_cnt != '0);
    pop          = coh_rvalid_o && coh_rready_i;
    push         = rst_ni && al_vld && al_idx;
    push_ok      = push && (!full || pop);
    coh_rways_o  = coh_rvalid_o ? mem_ways[rd_ptr] : '0;
    coh_rentry_o = coh_rvalid_o ? mem_ent[rd_ptr] : '0;
    coh_stall_o  = rst_ni && stall_raw;
    overflow_o   = rst_ni && overflow_q;
  end

  // FIFO storage write; contents are only observed through valid read pointers.
  always_ff @(posedge clk_i) begin
    if (push_ok) begin
      mem_ways[wr_ptr] <= al_ways;
      mem_ent[wr_ptr]  <= masked;
    end
  end

  // FIFO pointers, occupancy and the sticky overflow flag.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_cnt   <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)     rd_ptr <= ptr_inc(rd_ptr);
      case ({push_ok, pop})
        2'b10:   fifo_cnt <= fifo_cnt + CntW'(1);
        2'b01:   fifo_cnt <= fifo_cnt - CntW'(1);
        default: fifo_cnt <= fifo_cnt;
      endcase
      if (coh_drop) overflow_q <= 1'b1;
    end
  end

endmodule
